// File: rtl/cache_line_bridge_if.sv
// Bundles the upstream (cache line) and downstream (bus beat) handshakes
// of the cache line bridge. The bridge uses the slave view; the
// environment driving the cache side and modelling memory uses master.
//
// Handshake rule on every channel: a transfer happens on a rising clk
// edge where valid and ready are both 1. Once valid is high, the sender
// keeps it and its payload stable until that transfer.
interface cache_line_bridge_if #(
   parameter int ALL_ADDR_LEN = 24,
   parameter int MEMORY_DW    = 256,
   parameter int BUS_DW       = 32
);
   // upstream command / response (cache side)
   logic                    up_cmd_valid;
   logic                    up_cmd_ready;
   logic                    up_cmd_read;
   logic [ALL_ADDR_LEN-1:0] up_cmd_addr;
   logic [MEMORY_DW-1:0]    up_cmd_wdata;
   logic [MEMORY_DW/8-1:0]  up_cmd_wmask;
   logic                    up_rsp_valid;
   logic                    up_rsp_ready;
   logic [MEMORY_DW-1:0]    up_rsp_rdata;
   // downstream command / response (memory bus side)
   logic                    dn_cmd_valid;
   logic                    dn_cmd_ready;
   logic                    dn_cmd_read;
   logic [ALL_ADDR_LEN-1:0] dn_cmd_addr;
   logic [BUS_DW-1:0]       dn_cmd_wdata;
   logic [BUS_DW/8-1:0]     dn_cmd_wmask;
   logic                    dn_rsp_valid;
   logic                    dn_rsp_ready;
   logic [BUS_DW-1:0]       dn_rsp_rdata;

   modport slave (
      input  up_cmd_valid, up_cmd_read, up_cmd_addr, up_cmd_wdata, up_cmd_wmask,
      input  up_rsp_ready, dn_cmd_ready, dn_rsp_valid, dn_rsp_rdata,
      output up_cmd_ready, up_rsp_valid, up_rsp_rdata,
      output dn_cmd_valid, dn_cmd_read, dn_cmd_addr, dn_cmd_wdata, dn_cmd_wmask,
      output dn_rsp_ready
   );

   modport master (
      output up_cmd_valid, up_cmd_read, up_cmd_addr, up_cmd_wdata, up_cmd_wmask,
      output up_rsp_ready, dn_cmd_ready, dn_rsp_valid, dn_rsp_rdata,
      input  up_cmd_ready, up_rsp_valid, up_rsp_rdata,
      input  dn_cmd_valid, dn_cmd_read, dn_cmd_addr, dn_cmd_wdata, dn_cmd_wmask,
      input  dn_rsp_ready
   );
endinterface

// File: rtl/cache_line_bridge.sv
// Cache line bridge: splits one line read/write from the cache side into
// BEATS bus-width beats on the memory side, collects the in-order beat
// responses, and for reads returns the assembled line. Command issue and
// response collection run independently, so up to BEATS beats may be
// outstanding. BEATS is expected to be a power of two of at least 2.
module cache_line_bridge #(
   parameter int ALL_ADDR_LEN = 24,
   parameter int MEMORY_DW    = 256,
   parameter int BUS_DW       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   cache_line_bridge_if.slave   bus,
   output logic [1:0]           state_o
);
   localparam int BEATS     = MEMORY_DW / BUS_DW;
   localparam int BUS_BYTES = BUS_DW / 8;
   localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BOFF_W    = $clog2(BUS_BYTES);
   localparam int LINE_OFF  = $clog2(MEMORY_DW / 8);
   localparam int TAG_W     = ALL_ADDR_LEN - LINE_OFF;
   localparam int CNT_W     = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t                             state_q, state_d;
   logic [CNT_W-1:0]                   cmd_cnt_q, cmd_cnt_d;
   logic [CNT_W-1:0]                   rsp_cnt_q, rsp_cnt_d;
   logic                               read_q;
   logic [TAG_W-1:0]                   tag_q;
   logic [BEATS-1:0][BUS_DW-1:0]       wdata_q;
   logic [BEATS-1:0][BUS_BYTES-1:0]    wmask_q;
   logic [BEATS-1:0][BUS_DW-1:0]       line_q;

   logic             accept;
   logic             line_we;
   logic             cmd_valid;
   logic             rsp_ready;
   logic             cmd_ready_up;
   logic             rsp_valid_up;
   logic [IDX_W-1:0] cmd_idx;
   logic [IDX_W-1:0] rsp_idx;
   logic             addr_unused;

   // counters never exceed BEATS, so the low bits select the beat slice
   assign cmd_idx = cmd_cnt_q[IDX_W-1:0];
   assign rsp_idx = rsp_cnt_q[IDX_W-1:0];
   // offset bits inside the line are dropped: the line base is line aligned
   assign addr_unused = ^bus.up_cmd_addr[LINE_OFF-1:0];

   // next state, counter updates and handshake outputs
   always_comb begin
      state_d      = state_q;
      cmd_cnt_d    = cmd_cnt_q;
      rsp_cnt_d    = rsp_cnt_q;
      accept       = 1'b0;
      line_we      = 1'b0;
      cmd_valid    = 1'b0;
      rsp_ready    = 1'b0;
      cmd_ready_up = 1'b0;
      rsp_valid_up = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // held low while rst is asserted, as the bridge cannot accept then
            cmd_ready_up = !rst;
            if (bus.up_cmd_valid && !rst) begin
               accept    = 1'b1;
               cmd_cnt_d = '0;
               rsp_cnt_d = '0;
               state_d   = bus.up_cmd_read ? ST_READ : ST_WRITE;
            end
         end
         ST_WRITE, ST_READ: begin
            cmd_valid = (cmd_cnt_q < BEATS_C);
            rsp_ready = (rsp_cnt_q < BEATS_C);
            if (cmd_valid && bus.dn_cmd_ready) begin
               cmd_cnt_d = cmd_cnt_q + 1'b1;
            end
            if (rsp_ready && bus.dn_rsp_valid) begin
               rsp_cnt_d = rsp_cnt_q + 1'b1;
               line_we   = (state_q == ST_READ);
               if (rsp_cnt_q == LAST_C) begin
                  state_d = (state_q == ST_READ) ? ST_RESP : ST_IDLE;
               end
            end
         end
         ST_RESP: begin
            rsp_valid_up = 1'b1;
            if (bus.up_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and beat counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cmd_cnt_q <= '0;
         rsp_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cmd_cnt_q <= cmd_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
      end
   end

   // latch the accepted line command for the whole burst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_q  <= 1'b0;
         tag_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (accept) begin
         read_q  <= bus.up_cmd_read;
         tag_q   <= bus.up_cmd_addr[ALL_ADDR_LEN-1:LINE_OFF];
         wdata_q <= bus.up_cmd_wdata;
         wmask_q <= bus.up_cmd_wmask;
      end
   end

   // assemble read responses into the line buffer in arrival order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q <= '0;
      end else if (line_we) begin
         line_q[rsp_idx] <= bus.dn_rsp_rdata;
      end
   end

   // idle bus shows a harmless read with no data or byte enables
   assign bus.dn_cmd_valid = cmd_valid;
   assign bus.dn_cmd_read  = cmd_valid ? read_q : 1'b1;
   assign bus.dn_cmd_addr  = {tag_q, cmd_idx, {BOFF_W{1'b0}}};
   assign bus.dn_cmd_wdata = cmd_valid ? wdata_q[cmd_idx] : '0;
   assign bus.dn_cmd_wmask = cmd_valid ? wmask_q[cmd_idx] : '0;
   assign bus.dn_rsp_ready = rsp_ready;
   assign bus.up_cmd_ready = cmd_ready_up;
   assign bus.up_rsp_valid = rsp_valid_up;
   assign bus.up_rsp_rdata = line_q;
   assign state_o          = state_q;
endmodule

// File: doc/cache_line_bridge.md
CACHE_LINE_BRIDGE -- requirements
Module: cache_line_bridge

Interface
REQ-001 SHALL have parameter ALL_ADDR_LEN, default 24, byte-address width on both ports.
REQ-002 SHALL have parameter MEMORY_DW, default 256, cache line width.
REQ-003 SHALL have parameter BUS_DW, default 32, downstream beat width; BEATS = MEMORY_DW/BUS_DW (default 8).
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk input 1 (rising edge); rst input 1 (asynchronous, active-high).
REQ-005 SHALL have these upstream (cache side) ports:
- up_cmd_valid in 1: line request valid.
- up_cmd_ready out 1: request accepted; for writes, its rise also signals write completion.
- up_cmd_read in 1: 1 = line read, 0 = line write.
- up_cmd_addr in ALL_ADDR_LEN: byte address.
- up_cmd_wdata in MEMORY_DW: line data, low address in low bits.
- up_cmd_wmask in MEMORY_DW/8: byte enables.
- up_rsp_valid out 1, up_rsp_ready in 1, up_rsp_rdata out MEMORY_DW: assembled read line.
REQ-006 SHALL have these downstream (memory bus side) ports:
- dn_cmd_valid out 1, dn_cmd_ready in 1, dn_cmd_read out 1.
- dn_cmd_addr out ALL_ADDR_LEN, dn_cmd_wdata out BUS_DW, dn_cmd_wmask out BUS_DW/8.
- dn_rsp_valid in 1, dn_rsp_ready out 1, dn_rsp_rdata in BUS_DW.

Function
REQ-007 SHALL implement states IDLE, WRITE, READ, RESP.
REQ-008 SHALL drive up_cmd_ready=1 only in IDLE. A transfer occurs on up_cmd_valid&up_cmd_ready.
REQ-009 SHALL, on acceptance:
- latch read, wdata, wmask and line base = addr with low log2(MEMORY_DW/8) bits zeroed;
- clear cmd_cnt and rsp_cnt;
- go to READ if read=1, else WRITE.
REQ-010 SHALL, in READ/WRITE, drive dn_cmd_valid=1 while cmd_cnt<BEATS:
- dn_cmd_addr = base + cmd_cnt*(BUS_DW/8);
- dn_cmd_read = latched read;
- dn_cmd_wdata/wmask = slice cmd_cnt of latched wdata/wmask.
- cmd_cnt increments on dn_cmd_valid&dn_cmd_ready.
REQ-011 SHALL issue every beat, including beats whose mask is all zero.
REQ-012 SHALL drive dn_cmd_read=1, wdata=0, wmask=0 whenever dn_cmd_valid=0.
REQ-013 SHALL drive dn_rsp_ready=1 in READ/WRITE while rsp_cnt<BEATS, else 0. rsp_cnt increments on dn_rsp_valid&dn_rsp_ready.
REQ-014 SHALL allow command issue and response collection to overlap; outstanding beats (cmd_cnt-rsp_cnt) are unbounded up to BEATS.
REQ-015 SHALL, in READ, write dn_rsp_rdata into line buffer slice rsp_cnt on each accepted response. Responses are in order.
REQ-016 SHALL move WRITE->IDLE the cycle after the BEATS-th response is accepted; write response data is discarded.
REQ-017 SHALL move READ->RESP the cycle after the BEATS-th response is accepted.
REQ-018 SHALL, in RESP, hold up_rsp_valid=1 with up_rsp_rdata = line buffer stable until up_rsp_ready=1, then go to IDLE.
REQ-019 SHALL keep up_rsp_valid=0 in all states other than RESP.
REQ-020 SHALL ignore up_cmd_valid outside IDLE, and shall not accept a new command in the same cycle that RESP completes.
REQ-021 SHALL, with zero-wait downstream (ready=1, response one cycle after command) and acceptance at cycle 0:
- issue beats at cycles 1..8;
- receive responses at cycles 2..9;
- assert up_rsp_valid at cycle 10 for a read;
- assert up_cmd_ready at cycle 10 for a write.
REQ-022 SHALL wrap counters only via reset/acceptance; counters never exceed BEATS.

Reset
REQ-023 SHALL, on rst assertion at any time including mid-burst, immediately:
- set state to IDLE, cmd_cnt=0, rsp_cnt=0;
- clear the line buffer and latched command to 0;
- drive dn_cmd_valid=0, dn_rsp_ready=0, up_rsp_valid=0, up_cmd_ready=0.
REQ-024 SHALL drive up_cmd_ready=1 from the first clk edge after rst deassertion. Beats in flight at reset are dropped without completion.

Verification
REQ-025 SHALL verify line read: addr 0x001234 -> dn addrs 0x001220..0x00123C step 4; dn rsp data 0x0..0x7 -> up_rsp_rdata word k = k; up_rsp_valid at cycle 10.
REQ-026 SHALL verify line write: wdata word k = 0xA0+k, wmask all 1 -> 8 beats with wdata 0xA0..0xA7, wmask 0xF; up_cmd_ready low cycles 1..9, high at cycle 10.
REQ-027 SHALL verify backpressure: dn_cmd_ready toggled 1/0 every cycle, responses delayed 3 cycles -> all 8 beats issued in order, no beat duplicated or lost; line assembles correctly.
REQ-028 SHALL verify held response: up_rsp_ready=0 for 5 cycles in RESP -> up_rsp_valid and rdata stable; up_cmd_valid in that window is not accepted; IDLE follows ready.
REQ-029 SHALL verify mid-burst reset: rst pulsed after 3 read beats -> dn_cmd_valid=0 at once, up_rsp_valid never asserts; a new read after reset completes correctly.
REQ-030 SHALL verify partial mask: wmask only bytes 4..7 set -> beat 1 carries wmask 0xF; other beats carry wmask 0x0, all 8 beats still issued.
